// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel scheduler: modes, FSM states,
// colour width and the fixed 8-entry palette.
package vga_pkg;

  localparam int unsigned COLOR_W = 12;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_CYCLE  = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_BORDER = 2'd3
  } mode_e;

  typedef enum logic {
    WAIT_CFG = 1'b0,
    RUN      = 1'b1
  } state_e;

  localparam color_t PAL_0 = 12'h000;
  localparam color_t PAL_1 = 12'hF00;
  localparam color_t PAL_2 = 12'h0F0;
  localparam color_t PAL_3 = 12'h00F;
  localparam color_t PAL_4 = 12'hFF0;
  localparam color_t PAL_5 = 12'h0FF;
  localparam color_t PAL_6 = 12'hF0F;
  localparam color_t PAL_7 = 12'hFFF;

  function automatic color_t palette_color(input logic [2:0] idx);
    color_t c;
    case (idx)
      3'd0:    c = PAL_0;
      3'd1:    c = PAL_1;
      3'd2:    c = PAL_2;
      3'd3:    c = PAL_3;
      3'd4:    c = PAL_4;
      3'd5:    c = PAL_5;
      3'd6:    c = PAL_6;
      default: c = PAL_7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_palette_timer.sv
// Frame-paced palette index: advances pal_idx once every FRAMES_PER_STEP
// commits, so the cycle phase is independent of the selected mode.
module vga_palette_timer
  import vga_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       commit,
  output logic [2:0] pal_idx
);

  localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

  logic [STEP_W-1:0] step_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
      pal_idx  <= '0;
    end else if (commit) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        pal_idx  <= pal_idx + 3'd1;
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_pixel_scheduler.sv
// Per-pixel colour source selection for the VGA output. Configuration is
// committed at the first pixel of vertical blanking so frames never tear.
module vga_pixel_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY       = 640,
  parameter int unsigned V_DISPLAY       = 480,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter int unsigned BORDER_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [11:0] sw,
  input  logic [1:0]  mode,
  output logic [11:0] rgb,
  output logic [15:0] frame_cnt,
  output logic        cfg_active
);

  localparam logic [9:0] V_COMMIT  = 10'(V_DISPLAY);
  localparam logic [9:0] X_BORDER  = 10'(H_DISPLAY - BORDER_W);
  localparam logic [9:0] Y_BORDER  = 10'(V_DISPLAY - BORDER_W);
  localparam logic [9:0] BORDER_LO = 10'(BORDER_W);

  state_e     state, state_next;
  color_t     cfg_color;
  mode_e      cfg_mode;
  logic       commit;
  logic [2:0] pal_idx;
  logic [2:0] bar;
  logic       in_border;
  color_t     source;

  assign commit = p_tick && (x_pos == 10'd0) && (y_pos == V_COMMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_CFG;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == WAIT_CFG && commit) state_next = RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_color  <= '0;
      cfg_mode   <= MODE_SOLID;
      frame_cnt  <= '0;
      cfg_active <= 1'b0;
    end else if (commit) begin
      cfg_color  <= sw;
      cfg_mode   <= mode_e'(mode);
      frame_cnt  <= frame_cnt + 16'd1;
      cfg_active <= 1'b1;
    end
  end

  // The commit that leaves WAIT_CFG does not count as a palette frame.
  vga_palette_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .commit  (commit && (state == RUN)),
    .pal_idx (pal_idx)
  );

  // Bar index by comparison against k*H_DISPLAY/8; saturates at 7 past the edge.
  always_comb begin
    bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x_pos >= 10'(H_DISPLAY * k / 8)) bar = 3'(k);
    end
  end

  assign in_border = (x_pos < BORDER_LO) || (x_pos >= X_BORDER) ||
                     (y_pos < BORDER_LO) || (y_pos >= Y_BORDER);

  always_comb begin
    source = '0;
    case (cfg_mode)
      MODE_SOLID:  source = cfg_color;
      MODE_CYCLE:  source = palette_color(pal_idx);
      MODE_BARS:   source = palette_color(bar);
      MODE_BORDER: source = in_border ? cfg_color : '0;
      default:     source = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= '0;
    end else if (p_tick) begin
      rgb <= (state == RUN && video_on) ? source : '0;
    end
  end

endmodule
